// File: rtl/gf180mcu_fd_sc_mcu7t5v0__endcap_pwrseq.sv
// Row-end power-switch sequencer: enables NROWS header switches one row at a time and reports
// power-good once the chain acknowledges. Optional ack timeout: GF180MCU_FD_SC_MCU7T5V0__ENDCAP_PWRSEQ_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu7t5v0__endcap_pwrseq #(
    parameter int NROWS   = 8,
    parameter int DLY_W   = 4,
    parameter int ACK_TMO = 255
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             PWR_REQ,
    input  logic [DLY_W-1:0] DLY,
    input  logic             SW_ACK,
    output logic [NROWS-1:0] SW_EN,
    output logic             PWR_GOOD,
    output logic             BUSY,
    output logic             ERR
);

    localparam int STG_W = $clog2(NROWS + 1);
    localparam logic [STG_W-1:0] STG_ONE  = STG_W'(32'd1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(NROWS - 1);
    localparam logic [STG_W-1:0] STG_FULL = STG_W'(NROWS);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(32'd1);
    localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};

    generate
        if (NROWS < 2 || ACK_TMO < 1) begin : g_param_check
            $error("endcap_pwrseq: NROWS must be >= 2 and ACK_TMO >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RAMP_UP  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_ON       = 3'd3,
        ST_RAMP_DN  = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [STG_W-1:0]   stage_r, stage_nxt_s;
    logic [DLY_W-1:0]   dly_cnt_r, dly_cnt_nxt_s;
    logic [NROWS-1:0]   sw_en_r;
    logic               pwr_good_r, good_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [1:0]         ack_sync_r;
    logic               ack_s;
    logic               step_s;
    logic               tmo_hit_s;
    logic               lock_s;

    function automatic logic [NROWS-1:0] therm(input logic [STG_W-1:0] n);
        logic [NROWS-1:0] t;
        t = {NROWS{1'b0}};
        for (int i = 0; i < NROWS; i++) begin
            t[i] = (i < int'(n));
        end
        return t;
    endfunction

    assign ack_s  = ack_sync_r[1];
    assign step_s = (dly_cnt_r == DLY_ZERO);

    // Two-flop synchroniser for the analog acknowledge
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            ack_sync_r <= 2'b00;
        end else begin
            ack_sync_r <= {ack_sync_r[0], SW_ACK};
        end
    end

    // Next-state and next-output logic; the stage count is the number of rows switched on
    always_comb begin
        state_nxt_s   = state_r;
        stage_nxt_s   = stage_r;
        dly_cnt_nxt_s = dly_cnt_r;
        good_nxt_s    = pwr_good_r;
        busy_nxt_s    = busy_r;
        case (state_r)
            ST_OFF: begin
                good_nxt_s = 1'b0;
                if (PWR_REQ && !lock_s) begin
                    state_nxt_s   = ST_RAMP_UP;
                    stage_nxt_s   = STG_ONE;
                    dly_cnt_nxt_s = DLY;
                    busy_nxt_s    = 1'b1;
                end else begin
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_RAMP_UP: begin
                if (!PWR_REQ) begin
                    state_nxt_s   = ST_RAMP_DN;
                    dly_cnt_nxt_s = DLY;
                end else if (step_s) begin
                    stage_nxt_s   = stage_r + STG_ONE;
                    dly_cnt_nxt_s = DLY;
                    if (stage_r == STG_LAST) begin
                        state_nxt_s = ST_WAIT_ACK;
                    end else begin
                        state_nxt_s = ST_RAMP_UP;
                    end
                end else begin
                    dly_cnt_nxt_s = dly_cnt_r - DLY_ONE;
                end
            end
            ST_WAIT_ACK: begin
                if (!PWR_REQ) begin
                    state_nxt_s   = ST_RAMP_DN;
                    dly_cnt_nxt_s = DLY;
                end else if (ack_s) begin
                    state_nxt_s   = ST_ON;
                    good_nxt_s    = 1'b1;
                    busy_nxt_s    = 1'b0;
                end else if (tmo_hit_s) begin
                    state_nxt_s   = ST_RAMP_DN;
                    dly_cnt_nxt_s = DLY;
                end else begin
                    state_nxt_s   = ST_WAIT_ACK;
                end
            end
            ST_ON: begin
                if (!PWR_REQ) begin
                    state_nxt_s   = ST_RAMP_DN;
                    dly_cnt_nxt_s = DLY;
                    good_nxt_s    = 1'b0;
                    busy_nxt_s    = 1'b1;
                end else if (!ack_s) begin
                    state_nxt_s   = ST_WAIT_ACK;
                    good_nxt_s    = 1'b0;
                    busy_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s   = ST_ON;
                end
            end
            ST_RAMP_DN: begin
                // A reversal with every row still on goes straight back to waiting for ack
                if (PWR_REQ && !lock_s) begin
                    dly_cnt_nxt_s = DLY;
                    if (stage_r == STG_FULL) begin
                        state_nxt_s = ST_WAIT_ACK;
                    end else begin
                        state_nxt_s = ST_RAMP_UP;
                    end
                end else if (step_s) begin
                    stage_nxt_s   = stage_r - STG_ONE;
                    dly_cnt_nxt_s = DLY;
                    if (stage_r == STG_ONE) begin
                        state_nxt_s = ST_OFF;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = ST_RAMP_DN;
                    end
                end else begin
                    dly_cnt_nxt_s = dly_cnt_r - DLY_ONE;
                end
            end
            default: begin
                state_nxt_s   = ST_OFF;
                stage_nxt_s   = {STG_W{1'b0}};
                dly_cnt_nxt_s = DLY_ZERO;
                good_nxt_s    = 1'b0;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_r    <= ST_OFF;
            stage_r    <= {STG_W{1'b0}};
            dly_cnt_r  <= DLY_ZERO;
            sw_en_r    <= {NROWS{1'b0}};
            pwr_good_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            stage_r    <= stage_nxt_s;
            dly_cnt_r  <= dly_cnt_nxt_s;
            sw_en_r    <= therm(stage_nxt_s);
            pwr_good_r <= good_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__ENDCAP_PWRSEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(32'd1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;
    logic             lock_r;

    assign tmo_hit_s = (state_r == ST_WAIT_ACK) && PWR_REQ && !ack_s && (tmo_cnt_r == TMO_LAST);
    assign lock_s    = lock_r;
    assign ERR       = err_r;

    // Ack timeout: counts only while staying in WAIT_ACK; lockout holds OFF until the request drops
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            err_r     <= 1'b0;
            lock_r    <= 1'b0;
        end else begin
            if (state_r == ST_WAIT_ACK && state_nxt_s == ST_WAIT_ACK) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
            if (tmo_hit_s) begin
                err_r <= 1'b1;
            end else if (state_r == ST_OFF && state_nxt_s == ST_RAMP_UP) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            if (tmo_hit_s) begin
                lock_r <= 1'b1;
            end else if (!PWR_REQ) begin
                lock_r <= 1'b0;
            end else begin
                lock_r <= lock_r;
            end
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign lock_s    = 1'b0;
    assign ERR       = 1'b0;
`endif

    assign SW_EN    = sw_en_r;
    assign PWR_GOOD = pwr_good_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__endcap_pwrseq.sv
// Self-checking bench for the endcap power-switch sequencer: spec vectors, corner sequences and
// randomized traffic against a level/direction reference model.
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu7t5v0__endcap_pwrseq;

    localparam int NROWS   = 4;
    localparam int DLY_W   = 4;
    localparam int ACK_TMO = 10;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ENDCAP_PWRSEQ_TIMEOUT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RN = 1'b0;
    logic             PWR_REQ = 1'b0;
    logic [DLY_W-1:0] DLY = 4'd0;
    logic             SW_ACK = 1'b0;
    logic [NROWS-1:0] SW_EN;
    logic             PWR_GOOD, BUSY, ERR;
`ifdef USE_POWER_PINS
    wire VDD, VSS;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    gf180mcu_fd_sc_mcu7t5v0__endcap_pwrseq #(.NROWS(NROWS), .DLY_W(DLY_W), .ACK_TMO(ACK_TMO)) dut (
`ifdef USE_POWER_PINS
        .VDD(VDD), .VSS(VSS),
`endif
        .CLK(CLK), .RN(RN), .PWR_REQ(PWR_REQ), .DLY(DLY), .SW_ACK(SW_ACK),
        .SW_EN(SW_EN), .PWR_GOOD(PWR_GOOD), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: number of rows on, ramp direction (+1/-1/0) and a countdown to the next step
    int m_lvl, m_dir, m_tmr, m_tmo;
    bit m_good, m_busy, m_err, m_lock, m_s1, m_s2;

    task automatic m_reset();
        m_lvl = 0; m_dir = 0; m_tmr = 0; m_tmo = 0;
        m_good = 0; m_busy = 0; m_err = 0; m_lock = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step();
        bit ack;
        int want;
        ack  = m_s2;
        m_s2 = m_s1;
        m_s1 = SW_ACK;
        if (m_dir == 0 && m_lvl == 0) begin
            if (PWR_REQ && !m_lock) begin
                m_lvl = 1; m_dir = 1; m_tmr = int'(DLY); m_busy = 1; m_err = 0;
            end
        end else if (m_dir == 0 && m_good) begin
            if (!PWR_REQ) begin
                m_dir = -1; m_good = 0; m_busy = 1; m_tmr = int'(DLY);
            end else if (!ack) begin
                m_good = 0; m_busy = 1; m_tmo = 0;
            end
        end else if (m_dir == 0) begin
            if (!PWR_REQ) begin
                m_dir = -1; m_tmr = int'(DLY);
            end else if (ack) begin
                m_good = 1; m_busy = 0;
            end else if (FEAT && m_tmo == ACK_TMO - 1) begin
                m_err = 1; m_lock = 1; m_dir = -1; m_tmr = int'(DLY);
            end else begin
                m_tmo++;
            end
        end else begin
            want = (PWR_REQ && !m_lock) ? 1 : -1;
            if (want != m_dir) begin
                m_tmr = int'(DLY);
                if (want == 1 && m_lvl == NROWS) begin
                    m_dir = 0; m_tmo = 0;
                end else begin
                    m_dir = want;
                end
            end else if (m_tmr == 0) begin
                m_lvl += m_dir;
                m_tmr = int'(DLY);
                if (m_lvl == NROWS) begin m_dir = 0; m_tmo = 0; end
                if (m_lvl == 0)     begin m_dir = 0; m_busy = 0; end
            end else begin
                m_tmr--;
            end
        end
        if (!PWR_REQ) m_lock = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock: model follows the same sampled inputs; outputs compared 1ns after the edge
    task automatic cycle();
        logic [6:0] exp;
        @(posedge CLK);
        model_step();
        #1;
        exp = {4'(((1 << m_lvl) - 1)), m_good, m_busy, m_err};
        chk("model", {SW_EN, PWR_GOOD, BUSY, ERR}, exp);
    endtask

    task automatic do_reset(input logic [3:0] dly, input logic ack);
        @(negedge CLK);
        RN = 1'b0; PWR_REQ = 1'b0; DLY = dly; SW_ACK = ack;
        m_reset();
        @(negedge CLK);
        @(negedge CLK);
        RN = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
    endtask

    typedef struct {
        int         e;
        logic       req;
        logic [3:0] sw;
        logic       good;
        logic       busy;
    } vec_t;

    vec_t v12[15];
    logic [3:0] exp3[8];
    logic       req3[8];

    initial begin
        int e_cur;
        int bad;
        v12[0]  = '{0,  1'b1, 4'b0001, 1'b0, 1'b1};
        v12[1]  = '{2,  1'b1, 4'b0001, 1'b0, 1'b1};
        v12[2]  = '{3,  1'b1, 4'b0011, 1'b0, 1'b1};
        v12[3]  = '{6,  1'b1, 4'b0111, 1'b0, 1'b1};
        v12[4]  = '{8,  1'b1, 4'b0111, 1'b0, 1'b1};
        v12[5]  = '{9,  1'b1, 4'b1111, 1'b0, 1'b1};
        v12[6]  = '{10, 1'b1, 4'b1111, 1'b1, 1'b0};
        v12[7]  = '{19, 1'b1, 4'b1111, 1'b1, 1'b0};
        v12[8]  = '{20, 1'b0, 4'b1111, 1'b0, 1'b1};
        v12[9]  = '{22, 1'b0, 4'b1111, 1'b0, 1'b1};
        v12[10] = '{23, 1'b0, 4'b0111, 1'b0, 1'b1};
        v12[11] = '{26, 1'b0, 4'b0011, 1'b0, 1'b1};
        v12[12] = '{29, 1'b0, 4'b0001, 1'b0, 1'b1};
        v12[13] = '{31, 1'b0, 4'b0001, 1'b0, 1'b1};
        v12[14] = '{32, 1'b0, 4'b0000, 1'b0, 1'b0};
        exp3 = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
        req3 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #3;
        chk("reset_outputs", {SW_EN, PWR_GOOD, BUSY, ERR}, 7'd0);

        // Ramp up, power good, ramp down (NROWS=4, DLY=2)
        do_reset(4'd2, 1'b1);
        e_cur = -1;
        for (int i = 0; i < 15; i++) begin
            while (e_cur < v12[i].e) begin
                PWR_REQ = v12[i].req;
                cycle();
                e_cur++;
            end
            chk($sformatf("t12_e%0d_sw", v12[i].e), SW_EN, v12[i].sw);
            chk($sformatf("t12_e%0d_good", v12[i].e), PWR_GOOD, v12[i].good);
            chk($sformatf("t12_e%0d_busy", v12[i].e), BUSY, v12[i].busy);
        end

        // Reversal mid ramp-up (DLY=1)
        do_reset(4'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            PWR_REQ = req3[i];
            cycle();
            chk($sformatf("t3_e%0d_sw", i), SW_EN, exp3[i]);
        end
        chk("t3_busy_end", BUSY, 1'b0);

        if (!FEAT) begin
            // No ack: wait indefinitely, then ack (DLY=0 ramps one row per cycle)
            do_reset(4'd0, 1'b0);
            PWR_REQ = 1'b1;
            for (int i = 0; i < 4; i++) cycle();
            chk("t4_dly0_full", SW_EN, 4'b1111);
            bad = 0;
            for (int i = 0; i < 1000; i++) begin
                cycle();
                if (SW_EN !== 4'b1111 || BUSY !== 1'b1 || ERR !== 1'b0 || PWR_GOOD !== 1'b0) bad++;
            end
            chk("t4_hold_wait", 32'(bad), 32'd0);
            SW_ACK = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cycle();
                if (PWR_GOOD === 1'b1) break;
            end
            chk("t4_ack_good", PWR_GOOD, 1'b1);
            SW_ACK = 1'b0;
            for (int i = 0; i < 3; i++) cycle();
            chk("t4_ack_lost", {SW_EN, PWR_GOOD, BUSY}, {4'b1111, 1'b0, 1'b1});
        end else begin
            // Ack timeout, lockout, and ERR clear on restart
            do_reset(4'd0, 1'b0);
            PWR_REQ = 1'b1;
            for (int i = 0; i < 4; i++) cycle();
            chk("t5_full", SW_EN, 4'b1111);
            for (int i = 0; i < 9; i++) cycle();
            chk("t5_err_before", ERR, 1'b0);
            cycle();
            chk("t5_err_set", {ERR, SW_EN, BUSY}, {1'b1, 4'b1111, 1'b1});
            for (int i = 0; i < 4; i++) cycle();
            chk("t5_ramped_off", {SW_EN, BUSY}, {4'b0000, 1'b0});
            for (int i = 0; i < 5; i++) cycle();
            chk("t5_locked", {SW_EN, ERR}, {4'b0000, 1'b1});
            PWR_REQ = 1'b0;
            cycle();
            PWR_REQ = 1'b1;
            cycle();
            chk("t5_restart", {SW_EN, ERR}, {4'b0001, 1'b0});
        end

        // Asynchronous reset mid ramp-up
        do_reset(4'd3, 1'b1);
        PWR_REQ = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_pre", SW_EN, 4'b0011);
        #2;
        RN = 1'b0;
        m_reset();
        #1;
        chk("t6_async", {SW_EN, PWR_GOOD, BUSY}, 6'd0);
        @(negedge CLK);
        RN = 1'b1;
        cycle();
        chk("t6_restart", SW_EN, 4'b0001);

        // Randomized traffic against the reference model
        do_reset(4'd0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) PWR_REQ = ~PWR_REQ;
            if ($urandom_range(0, 29) == 0) SW_ACK = ~SW_ACK;
            DLY = 4'($urandom_range(0, 3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
